// File: rtl/ramcpld_pkg.sv
// Shared definitions for the RAM CPLD refresh logic.
//   ref_state_t  : CBR sequencer state encoding
//   DEF_*        : default interval, backlog limit and CBR cycle counts
//   OWED_W       : width of the refresh backlog counter
//   PHASE_W      : width of the shared RAS_LOW / PRECHARGE phase counter
package ramcpld_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CAS_SETUP = 2'd1,
    ST_RAS_LOW   = 2'd2,
    ST_PRECHARGE = 2'd3
  } ref_state_t;

  localparam int DEF_REFRESH_INTERVAL = 390;
  localparam int DEF_MAX_OWED         = 8;
  localparam int DEF_URGENT_LEVEL     = 4;
  localparam int DEF_RAS_CYCLES       = 2;
  localparam int DEF_PRECHARGE_CYCLES = 2;

  localparam int OWED_W  = 4;
  localparam int PHASE_W = 4;

endpackage

// File: rtl/refresh_timer.sv
// Wall-clock refresh interval timer.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   enable : counter runs while high, held at 0 while low
//   tick   : one-cycle pulse in the last cycle of every interval
module refresh_timer #(
  parameter int INTERVAL = 390
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(INTERVAL - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Decoded from the registered count, so it is clean for internal use.
  assign tick = enable && (count == LAST);

endmodule

// File: rtl/dram_refresh_sched.sv
// CAS-before-RAS refresh scheduler for the FAST RAM DRAM array.
// Keeps a saturating backlog of owed refreshes, requests the bus with
// REF_REQ/REF_GNT and, once granted, plays one complete CBR sequence on
// REF_RAS/REF_CAS.
//   CLKCPU     : clock (rising edge)
//   RESET      : asynchronous active-low reset
//   ENABLE     : refresh interval timer runs while high
//   REF_GNT    : grant from the DRAM controller
//   REF_REQ    : refresh owed and sequencer idle
//   REF_URGENT : backlog at or above URGENT_LEVEL
//   REF_BUSY   : CBR sequence in progress (controller muxes strobes)
//   REF_RAS    : active-low RAS, both banks
//   REF_CAS    : active-low CAS, all byte lanes
//   REF_DONE   : one-cycle pulse in the final precharge cycle
//   OWED       : current backlog
//   OVERRUN    : sticky, a tick was dropped at full backlog
//   fsm_state  : current sequencer state (debug)
//
// Handshake: REF_REQ is a registered level; a sequence starts at the rising
// edge where REF_REQ and REF_GNT are both high. After that edge REF_GNT is
// ignored until the sequencer is back in IDLE; a CBR is never aborted.
//
// All strobe/status outputs are registered, decoded from the next-state
// values, so they change only at clock edges and never glitch.
module dram_refresh_sched
  import ramcpld_pkg::*;
#(
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int MAX_OWED         = DEF_MAX_OWED,
  parameter int URGENT_LEVEL     = DEF_URGENT_LEVEL,
  parameter int RAS_CYCLES       = DEF_RAS_CYCLES,
  parameter int PRECHARGE_CYCLES = DEF_PRECHARGE_CYCLES
) (
  input  logic              CLKCPU,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              REF_GNT,
  output logic              REF_REQ,
  output logic              REF_URGENT,
  output logic              REF_BUSY,
  output logic [1:0]        REF_RAS,
  output logic [3:0]        REF_CAS,
  output logic              REF_DONE,
  output logic [OWED_W-1:0] OWED,
  output logic              OVERRUN,
  output ref_state_t        fsm_state
);

  localparam logic [OWED_W-1:0]  OWED_MAX   = OWED_W'(MAX_OWED);
  localparam logic [OWED_W-1:0]  OWED_URG   = OWED_W'(URGENT_LEVEL);
  localparam logic [PHASE_W-1:0] RAS_LAST   = PHASE_W'(RAS_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PRE_LAST   = PHASE_W'(PRECHARGE_CYCLES - 1);

  ref_state_t         state, state_next;
  logic [PHASE_W-1:0] phase, phase_next;
  logic [OWED_W-1:0]  owed_next;
  logic               overrun_next;
  logic               tick;
  logic               cbr_done;

  logic               req_d, urgent_d, busy_d, done_d;
  logic [1:0]         ras_d;
  logic [3:0]         cas_d;

  refresh_timer #(
    .INTERVAL (REFRESH_INTERVAL)
  ) u_timer (
    .clk    (CLKCPU),
    .rst_n  (RESET),
    .enable (ENABLE),
    .tick   (tick)
  );

  // Last precharge cycle: the refresh just performed is retired at its end.
  assign cbr_done = (state == ST_PRECHARGE) && (phase == PRE_LAST);

  // State and output registers.
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      phase      <= '0;
      OWED       <= '0;
      OVERRUN    <= 1'b0;
      REF_REQ    <= 1'b0;
      REF_URGENT <= 1'b0;
      REF_BUSY   <= 1'b0;
      REF_RAS    <= 2'b11;
      REF_CAS    <= 4'hF;
      REF_DONE   <= 1'b0;
    end else begin
      state      <= state_next;
      phase      <= phase_next;
      OWED       <= owed_next;
      OVERRUN    <= overrun_next;
      REF_REQ    <= req_d;
      REF_URGENT <= urgent_d;
      REF_BUSY   <= busy_d;
      REF_RAS    <= ras_d;
      REF_CAS    <= cas_d;
      REF_DONE   <= done_d;
    end
  end

  // Next state. RAS_LOW and PRECHARGE share one phase counter.
  always_comb begin
    state_next = state;
    phase_next = phase;
    case (state)
      ST_IDLE: begin
        if (REF_REQ && REF_GNT) begin
          state_next = ST_CAS_SETUP;
          phase_next = '0;
        end
      end
      ST_CAS_SETUP: begin
        state_next = ST_RAS_LOW;
        phase_next = '0;
      end
      ST_RAS_LOW: begin
        if (phase == RAS_LAST) begin
          state_next = ST_PRECHARGE;
          phase_next = '0;
        end else begin
          phase_next = phase + PHASE_W'(1);
        end
      end
      ST_PRECHARGE: begin
        if (phase == PRE_LAST) begin
          state_next = ST_IDLE;
          phase_next = '0;
        end else begin
          phase_next = phase + PHASE_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        phase_next = '0;
      end
    endcase
  end

  // Backlog. A tick coinciding with a completion cancels out; a tick at
  // full backlog with no completion is dropped and flagged.
  always_comb begin
    owed_next    = OWED;
    overrun_next = OVERRUN;
    if (tick && !cbr_done) begin
      if (OWED == OWED_MAX) begin
        overrun_next = 1'b1;
      end else begin
        owed_next = OWED + OWED_W'(1);
      end
    end else if (cbr_done && !tick) begin
      if (OWED != '0) begin
        owed_next = OWED - OWED_W'(1);
      end
    end
  end

  // Output decode from next-state values, registered above.
  always_comb begin
    busy_d   = (state_next != ST_IDLE);
    ras_d    = 2'b11;
    cas_d    = 4'hF;
    done_d   = 1'b0;
    req_d    = (owed_next != '0) && (state_next == ST_IDLE);
    urgent_d = (owed_next >= OWED_URG);
    case (state_next)
      ST_CAS_SETUP: begin
        cas_d = 4'h0;
      end
      ST_RAS_LOW: begin
        ras_d = 2'b00;
        cas_d = 4'h0;
      end
      ST_PRECHARGE: begin
        done_d = (phase_next == PRE_LAST);
      end
      default: begin
        ras_d = 2'b11;
      end
    endcase
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_dram_refresh_sched.sv
// Self-checking bench for dram_refresh_sched at default parameters.
module tb_dram_refresh_sched;
  import ramcpld_pkg::*;

  localparam int INTERVAL = 390;

  logic       CLKCPU = 1'b0;
  logic       RESET  = 1'b0;
  logic       ENABLE = 1'b0;
  logic       REF_GNT = 1'b0;
  logic       REF_REQ, REF_URGENT, REF_BUSY, REF_DONE, OVERRUN;
  logic [1:0] REF_RAS;
  logic [3:0] REF_CAS;
  logic [3:0] OWED;
  ref_state_t fsm_state;

  int errors = 0;
  int checks = 0;

  // Scoreboard entry: {busy, ras[1:0], cas[3:0], done, owed[3:0]}
  logic [11:0] exp_q[$];

  dram_refresh_sched dut (
    .CLKCPU     (CLKCPU),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .REF_GNT    (REF_GNT),
    .REF_REQ    (REF_REQ),
    .REF_URGENT (REF_URGENT),
    .REF_BUSY   (REF_BUSY),
    .REF_RAS    (REF_RAS),
    .REF_CAS    (REF_CAS),
    .REF_DONE   (REF_DONE),
    .OWED       (OWED),
    .OVERRUN    (OVERRUN),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 CLKCPU = ~CLKCPU;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLKCPU);
    #1;
  endtask

  task automatic do_reset(input logic en);
    RESET   = 1'b0;
    ENABLE  = 1'b0;
    REF_GNT = 1'b0;
    repeat (2) step();
    ENABLE = en;
    RESET  = 1'b1;
  endtask

  function automatic logic [11:0] ent(input logic busy, input logic [1:0] ras,
                                      input logic [3:0] cas, input logic done,
                                      input logic [3:0] owed);
    return {busy, ras, cas, done, owed};
  endfunction

  // Expected per-cycle view of one CBR sequence plus the IDLE cycle after it.
  task automatic push_seq(input logic [3:0] owed_during, input logic [3:0] owed_after);
    exp_q.push_back(ent(1'b1, 2'b11, 4'h0, 1'b0, owed_during));
    exp_q.push_back(ent(1'b1, 2'b00, 4'h0, 1'b0, owed_during));
    exp_q.push_back(ent(1'b1, 2'b00, 4'h0, 1'b0, owed_during));
    exp_q.push_back(ent(1'b1, 2'b11, 4'hF, 1'b0, owed_during));
    exp_q.push_back(ent(1'b1, 2'b11, 4'hF, 1'b1, owed_during));
    exp_q.push_back(ent(1'b0, 2'b11, 4'hF, 1'b0, owed_after));
  endtask

  // Clocks through one queued sequence; drops REF_GNT after step drop_at.
  task automatic run_seq(input string name, input int drop_at, output int busy_cycles);
    logic [11:0] exp, got;
    busy_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == drop_at) REF_GNT = 1'b0;
      got = {REF_BUSY, REF_RAS, REF_CAS, REF_DONE, OWED};
      if (REF_BUSY) busy_cycles++;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got {busy,ras,cas,done,owed}=%h expected %h",
                 name, i, got, exp);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b0;
    repeat (2) step();
    checks++;
    if ({REF_REQ, REF_URGENT, REF_BUSY, REF_RAS, REF_CAS, REF_DONE, OWED, OVERRUN}
        !== {1'b0, 1'b0, 1'b0, 2'b11, 4'hF, 1'b0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: req=%b urg=%b busy=%b ras=%b cas=%h done=%b owed=%0d ovr=%b",
               REF_REQ, REF_URGENT, REF_BUSY, REF_RAS, REF_CAS, REF_DONE, OWED, OVERRUN);
    end
    checks++;
    if (fsm_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE);
    end
  endtask

  task automatic test_enable_low();
    do_reset(1'b0);
    repeat (500) step();
    checks++;
    if (OWED !== 4'd0 || REF_REQ !== 1'b0) begin
      errors++;
      $display("FAIL enable_low: owed=%0d req=%b expected owed=0 req=0", OWED, REF_REQ);
    end
  endtask

  task automatic test_basic_request();
    do_reset(1'b1);
    repeat (INTERVAL - 1) step();
    checks++;
    if (OWED !== 4'd0 || REF_REQ !== 1'b0) begin
      errors++;
      $display("FAIL before_first_tick: owed=%0d req=%b expected 0/0", OWED, REF_REQ);
    end
    step();
    checks++;
    if (OWED !== 4'd1 || REF_REQ !== 1'b1 || REF_URGENT !== 1'b0) begin
      errors++;
      $display("FAIL first_tick: owed=%0d req=%b urg=%b expected 1/1/0", OWED, REF_REQ, REF_URGENT);
    end
  endtask

  // Continues from test_basic_request: OWED = 1, REF_REQ = 1.
  task automatic test_single_sequence();
    int busy;
    REF_GNT = 1'b1;
    push_seq(4'd1, 4'd0);
    run_seq("single_seq", -1, busy);
    REF_GNT = 1'b0;
    checks++;
    if (busy != 5) begin
      errors++;
      $display("FAIL single_busy_len: got %0d expected 5", busy);
    end
    checks++;
    if (REF_REQ !== 1'b0 || OWED !== 4'd0) begin
      errors++;
      $display("FAIL single_after: req=%b owed=%0d expected 0/0", REF_REQ, OWED);
    end
  endtask

  task automatic test_saturation();
    int exp_owed = 0;
    logic exp_ovr = 1'b0;
    int busy;
    do_reset(1'b1);
    for (int k = 1; k <= 10 * INTERVAL; k++) begin
      step();
      if (k % INTERVAL == 0) begin
        if (exp_owed == 8) exp_ovr = 1'b1;
        else exp_owed++;
      end
      if (k % INTERVAL == 0 || k % INTERVAL == INTERVAL - 1) begin
        checks++;
        if (OWED !== 4'(exp_owed) || REF_URGENT !== (exp_owed >= 4) || OVERRUN !== exp_ovr) begin
          errors++;
          $display("FAIL saturate k=%0d: owed=%0d urg=%b ovr=%b expected %0d/%b/%b",
                   k, OWED, REF_URGENT, OVERRUN, exp_owed, (exp_owed >= 4), exp_ovr);
        end
      end
    end
    // Drain the full backlog with a continuously held grant.
    REF_GNT = 1'b1;
    for (int s = 0; s < 8; s++) begin
      push_seq(4'(8 - s), 4'(7 - s));
      run_seq("drain_seq", -1, busy);
    end
    REF_GNT = 1'b0;
    step();
    checks++;
    if (OWED !== 4'd0 || REF_REQ !== 1'b0 || REF_URGENT !== 1'b0 || OVERRUN !== 1'b1) begin
      errors++;
      $display("FAIL drained: owed=%0d req=%b urg=%b ovr=%b expected 0/0/0/1",
               OWED, REF_REQ, REF_URGENT, OVERRUN);
    end
  endtask

  // The 4th tick (edge 4*INTERVAL) lands on the completion edge at OWED = 3.
  task automatic test_tick_and_done();
    int busy;
    do_reset(1'b1);
    repeat (4 * INTERVAL - 6) step();
    checks++;
    if (OWED !== 4'd3) begin
      errors++;
      $display("FAIL tick_done_pre: owed=%0d expected 3", OWED);
    end
    REF_GNT = 1'b1;
    push_seq(4'd3, 4'd3);
    run_seq("tick_and_done", 0, busy);
  endtask

  task automatic test_grant_drop();
    int busy;
    do_reset(1'b1);
    repeat (INTERVAL) step();
    REF_GNT = 1'b1;
    push_seq(4'd1, 4'd0);
    run_seq("grant_drop", 1, busy);
    checks++;
    if (busy != 5 || REF_REQ !== 1'b0) begin
      errors++;
      $display("FAIL grant_drop_after: busy=%0d req=%b expected 5/0", busy, REF_REQ);
    end
  endtask

  task automatic test_reset_abort();
    do_reset(1'b1);
    repeat (INTERVAL) step();
    REF_GNT = 1'b1;
    repeat (2) step();
    checks++;
    if (REF_RAS !== 2'b00 || fsm_state !== ST_RAS_LOW) begin
      errors++;
      $display("FAIL abort_in_ras_low: ras=%b state=%0d expected 00/%0d",
               REF_RAS, fsm_state, ST_RAS_LOW);
    end
    #2 RESET = 1'b0;
    #1;
    checks++;
    if (REF_RAS !== 2'b11 || REF_CAS !== 4'hF || OWED !== 4'd0 || REF_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: ras=%b cas=%h owed=%0d busy=%b expected 11/f/0/0",
               REF_RAS, REF_CAS, OWED, REF_BUSY);
    end
    REF_GNT = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_enable_low();
    test_basic_request();
    test_single_sequence();
    test_saturation();
    test_tick_and_done();
    test_grant_drop();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
